// File: rtl/prog_loader.sv
// prog_loader: host-side initiator for the cpu external memory ports.
// Streams a program into IMEM, runs the cpu for a latched number of cycles,
// then reads a window of DMEM and streams it out over a valid/ready link.
// Optional feature: define LOADER_READBACK_EN to add a VERIFY pass that
// re-reads IMEM after loading and flags a checksum mismatch on err.
module prog_loader #(
    parameter int DATA_W    = 32,
    parameter int PLEN_W    = 10,
    parameter int DLEN_W    = 11,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PLEN_W-1:0] prog_len,
    input  logic [31:0]       run_cycles,
    input  logic [31:0]       dump_base,
    input  logic [DLEN_W-1:0] dump_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_enable,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    input  logic [DATA_W-1:0] rdata_ext,
    output logic [31:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2
);

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP_RD,
        S_DUMP_WAIT,
        S_DUMP_OUT,
        S_DONE
`ifdef LOADER_READBACK_EN
        , S_VERIFY
`endif
    } state_t;

    state_t             state, state_n;
    logic [PLEN_W-1:0]  plen_q;
    logic [31:0]        run_q;
    logic [31:0]        base_q;
    logic [DLEN_W-1:0]  dlen_q;
    logic [PLEN_W-1:0]  word_cnt;
    logic [31:0]        run_cnt;
    logic [DLEN_W-1:0]  dump_cnt;
    logic [DATA_W-1:0]  data_q;

    logic [PLEN_W-1:0]  word_next;
    logic [DLEN_W-1:0]  dump_next;
    logic               load_last;
    logic               run_last;
    logic               dump_last;

    assign word_next = word_cnt + 1'b1;
    assign dump_next = dump_cnt + 1'b1;
    assign load_last = (word_next == plen_q);
    assign run_last  = ((run_cnt + 32'd1) == run_q);
    assign dump_last = (dump_next == dlen_q);

`ifdef LOADER_READBACK_EN
    logic [31:0] load_sum;
    logic [31:0] read_sum;
    logic [31:0] sum_now;
    logic        rd_pend;
    logic        err_q;
    logic        ver_issue;
    logic        ver_bad;

    // A read is issued while words remain; the last cycle only collects data.
    assign ver_issue = (word_cnt != plen_q);
    assign sum_now   = read_sum + (rd_pend ? 32'(rdata_ext) : 32'd0);
    assign ver_bad   = (sum_now != load_sum);
`else
    logic unused_rdata;
    assign unused_rdata = ^rdata_ext;
`endif

    // Phase that follows a (possibly skipped) load, chosen from run/dump lengths.
    function automatic state_t after_load(input logic [31:0] run,
                                          input logic [DLEN_W-1:0] dlen);
        if (run != 32'd0)
            return S_RUN;
        else if (dlen != '0)
            return S_DUMP_RD;
        else
            return S_DONE;
    endfunction

    // State register, latched parameters, counters and captured dump word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            plen_q   <= '0;
            run_q    <= '0;
            base_q   <= '0;
            dlen_q   <= '0;
            word_cnt <= '0;
            run_cnt  <= '0;
            dump_cnt <= '0;
            data_q   <= '0;
`ifdef LOADER_READBACK_EN
            load_sum <= '0;
            read_sum <= '0;
            rd_pend  <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // the same pre-edge values regardless of statement order.
            state <= state_n;
            case (state)
                S_IDLE: if (start) begin
                    plen_q   <= prog_len;
                    run_q    <= run_cycles;
                    base_q   <= dump_base;
                    dlen_q   <= dump_len;
                    word_cnt <= '0;
                    run_cnt  <= '0;
                    dump_cnt <= '0;
`ifdef LOADER_READBACK_EN
                    load_sum <= '0;
                    read_sum <= '0;
                    rd_pend  <= 1'b0;
                    err_q    <= 1'b0;
`endif
                end
                S_LOAD: if (in_valid) begin
                    word_cnt <= load_last ? '0 : word_next;
`ifdef LOADER_READBACK_EN
                    load_sum <= load_sum + 32'(in_data);
`endif
                end
`ifdef LOADER_READBACK_EN
                S_VERIFY: begin
                    if (ver_issue)
                        word_cnt <= word_next;
                    rd_pend  <= ver_issue;
                    read_sum <= sum_now;
                    if (!ver_issue && ver_bad)
                        err_q <= 1'b1;
                end
`endif
                S_RUN:       run_cnt <= run_cnt + 32'd1;
                S_DUMP_WAIT: data_q <= rdata_ext_2;
                S_DUMP_OUT:  if (out_ready) dump_cnt <= dump_next;
                default: ;
            endcase
        end
    end

    // Next-state and outputs; everything is forced low while rst is high.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_n     = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        cpu_enable  = 1'b0;
        addr_ext    = '0;
        wen_ext     = 1'b0;
        ren_ext     = 1'b0;
        wdata_ext   = '0;
        addr_ext_2  = '0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        wdata_ext_2 = '0;
        if (!rst) begin
            busy     = (state != S_IDLE);
            out_data = data_q;
`ifdef LOADER_READBACK_EN
            err      = err_q;
`endif
            case (state)
                S_IDLE: if (start)
                    state_n = (prog_len != '0) ? S_LOAD : after_load(run_cycles, dump_len);
                S_LOAD: begin
                    in_ready = 1'b1;
                    addr_ext = 32'(word_cnt) * STEP;
                    if (in_valid) begin
                        wen_ext   = 1'b1;
                        wdata_ext = in_data;
                        if (load_last)
`ifdef LOADER_READBACK_EN
                            state_n = S_VERIFY;
`else
                            state_n = after_load(run_q, dlen_q);
`endif
                    end
                end
`ifdef LOADER_READBACK_EN
                S_VERIFY: begin
                    addr_ext = 32'(word_cnt) * STEP;
                    ren_ext  = ver_issue;
                    if (!ver_issue)
                        state_n = ver_bad ? S_DONE : after_load(run_q, dlen_q);
                end
`endif
                S_RUN: begin
                    cpu_enable = 1'b1;
                    if (run_last)
                        state_n = (dlen_q != '0) ? S_DUMP_RD : S_DONE;
                end
                S_DUMP_RD: begin
                    ren_ext_2  = 1'b1;
                    addr_ext_2 = base_q + 32'(dump_cnt) * STEP;
                    state_n    = S_DUMP_WAIT;
                end
                S_DUMP_WAIT: state_n = S_DUMP_OUT;
                S_DUMP_OUT: begin
                    out_valid = 1'b1;
                    if (out_ready)
                        state_n = dump_last ? S_DONE : S_DUMP_RD;
                end
                S_DONE: begin
                    done    = 1'b1;
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader with IMEM/DMEM models.
// Expected behaviour is derived from the sequence parameters: k-th program
// word written at 4*k, cpu_enable high run_cycles contiguous cycles, dump word
// j read from dump_base+4*j and delivered in order, exactly one done pulse.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  prog_len;
    logic [31:0] run_cycles;
    logic [31:0] dump_base;
    logic [10:0] dump_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_enable;
    logic [31:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext;
    logic [31:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [31:0] wdata_ext_2;
    logic [31:0] rdata_ext_2;

    int errors = 0;
    int checks = 0;

    logic [31:0] imem [512];
    logic [31:0] dmem [1024];
    bit          corrupt = 1'b0;
    logic [31:0] prog_q [$];

    prog_loader dut (
        .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
        .run_cycles(run_cycles), .dump_base(dump_base), .dump_len(dump_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .err(err), .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
    );

    always #5 clk = ~clk;

    // Memory models: one-cycle read latency; IMEM can corrupt word 1 on read.
    always @(posedge clk) begin
        if (wen_ext)
            imem[addr_ext[10:2]] <= wdata_ext;
        if (ren_ext)
            rdata_ext <= imem[addr_ext[10:2]] ^
                         ((corrupt && addr_ext[10:2] == 9'd1) ? 32'h0000_0100 : 32'h0);
        if (ren_ext_2)
            rdata_ext_2 <= dmem[addr_ext_2[11:2]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one full sequence from IDLE (caller sits at posedge+1) and checks it.
    task automatic run_seq(input int plen, input logic [31:0] run, input logic [31:0] base,
                           input int dlen, input bit gaps, input int stall,
                           input bit expect_err, output int done_cyc);
        logic [31:0] wr_a [$];
        logic [31:0] wr_d [$];
        logic [31:0] rd2 [$];
        logic [31:0] outs [$];
        logic [31:0] held_data;
        logic [31:0] a;
        int pidx = 0, en_cnt = 0, en_first = -1, en_last = -1;
        int ren_cnt = 0, wen2_cnt = 0, ren2_first = -1, stall_left = stall;
        int exp_en, exp_d, exp_ren, budget;
        bit held = 1'b0, fin = 1'b0;

        done_cyc   = -1;
        budget     = plen * 10 + int'(run) + dlen * 12 + stall + 60;
        prog_len   = 10'(plen);
        run_cycles = run;
        dump_base  = base;
        dump_len   = 11'(dlen);
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        prog_len   = 10'($urandom);
        run_cycles = $urandom;
        dump_base  = $urandom;
        dump_len   = 11'($urandom);

        for (int c = 0; c < budget && !fin; c++) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = (pidx < plen) ? prog_q[pidx] : $urandom;
            start    = ($urandom_range(0, 3) == 0);
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(negedge clk);
            if (wen_ext) begin
                wr_a.push_back(addr_ext);
                wr_d.push_back(wdata_ext);
            end
            if (in_valid && in_ready) pidx++;
            if (ren_ext) ren_cnt++;
            if (wen_ext_2 || wdata_ext_2 != 32'h0) wen2_cnt++;
            if (cpu_enable) begin
                en_cnt++;
                if (en_first < 0) en_first = c;
                en_last = c;
            end
            if (ren_ext_2) begin
                rd2.push_back(addr_ext_2);
                if (ren2_first < 0) ren2_first = c;
            end
            if (held) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(held_data));
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            if (out_valid && out_ready) outs.push_back(out_data);
            if (done) begin
                fin      = 1'b1;
                done_cyc = c;
            end
            @(posedge clk); #1;
        end

        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("done_seen", 64'(fin), 64'd1);
        if (!fin) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("done_single", 64'(done), 64'd0);
        check("err_flag", 64'(err), 64'(expect_err));
        @(posedge clk); #1;

        check("wr_count", 64'(wr_a.size()), 64'(plen));
        for (int k = 0; k < plen && k < wr_a.size(); k++) begin
            check($sformatf("wr_addr[%0d]", k), 64'(wr_a[k]), 64'(32'(4 * k)));
            check($sformatf("wr_data[%0d]", k), 64'(wr_d[k]), 64'(prog_q[k]));
        end
        exp_en = expect_err ? 0 : int'(run);
        check("enable_cycles", 64'(en_cnt), 64'(exp_en));
        if (en_cnt > 0)
            check("enable_contig", 64'(en_last - en_first + 1), 64'(en_cnt));
        exp_d = expect_err ? 0 : dlen;
        check("dump_reads", 64'(rd2.size()), 64'(exp_d));
        check("dump_outs", 64'(outs.size()), 64'(exp_d));
        for (int j = 0; j < exp_d && j < rd2.size(); j++) begin
            a = base + 32'(4 * j);
            check($sformatf("dump_addr[%0d]", j), 64'(rd2[j]), 64'(a));
        end
        for (int j = 0; j < exp_d && j < outs.size(); j++) begin
            a = base + 32'(4 * j);
            check($sformatf("dump_data[%0d]", j), 64'(outs[j]), 64'(dmem[a[11:2]]));
        end
        if (en_cnt > 0 && ren2_first >= 0)
            check("dump_after_run", 64'(ren2_first), 64'(en_last + 1));
`ifdef LOADER_READBACK_EN
        exp_ren = plen;
`else
        exp_ren = 0;
`endif
        check("imem_reads", 64'(ren_cnt), 64'(exp_ren));
        check("dmem_writes", 64'(wen2_cnt), 64'd0);
    endtask

    initial begin
        int dc;
        int en_seen;

        rst = 1'b1; start = 1'b0; prog_len = '0; run_cycles = '0;
        dump_base = '0; dump_len = '0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        for (int i = 0; i < 1024; i++) dmem[i] = $urandom;
        dmem[4] = 32'hA;
        dmem[5] = 32'hB;

        // Reset state: outputs low while rst is held.
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outs", 64'({done, err, cpu_enable, in_ready, out_valid,
                               wen_ext, ren_ext, ren_ext_2, wen_ext_2}), 64'd0);
        check("rst_addr", 64'({addr_ext, addr_ext_2}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd0);
        check("idle_no_write", 64'(wen_ext), 64'd0);
        @(posedge clk); #1;

        // Directed: three-word program, 10 run cycles, stalled two-word dump.
        prog_q = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820};
        run_seq(3, 32'd10, 32'h10, 2, 1'b0, 3, 1'b0, dc);

        // All lengths zero: done one cycle after start, no memory traffic.
        prog_q.delete();
        run_seq(0, 32'd0, 32'h0, 0, 1'b0, 0, 1'b0, dc);
        check("zero_done_cycle", 64'(dc), 64'd0);

        // Dump address wraps past 2^32.
        prog_q = '{32'h1111_1111, 32'h2222_2222};
        run_seq(2, 32'd1, 32'hFFFF_FFF8, 4, 1'b1, 2, 1'b0, dc);

        // Reset in the middle of RUN, then relaunch.
        prog_len = 10'd1; run_cycles = 32'd40; dump_base = 32'h0; dump_len = 11'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678;
        en_seen = 0;
        for (int c = 0; c < 60 && en_seen < 5; c++) begin
            @(negedge clk);
            if (cpu_enable) en_seen++;
            if (en_seen < 5) begin
                @(posedge clk); #1;
            end
        end
        check("rst_run_reached", 64'(en_seen), 64'd5);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("rst_cycle_quiet", 64'({cpu_enable, wen_ext, ren_ext_2, done}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_enable", 64'(cpu_enable), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        prog_q = '{32'hCAFE_0001, 32'hCAFE_0002};
        run_seq(2, 32'd5, $urandom, 3, 1'b1, 1, 1'b0, dc);

        // Randomized sequences with handshake gaps and back-pressure.
        for (int t = 0; t < 6; t++) begin
            int pl, dl;
            logic [31:0] rc;
            pl = $urandom_range(0, 20);
            rc = 32'($urandom_range(0, 30));
            dl = $urandom_range(0, 8);
            prog_q.delete();
            for (int k = 0; k < pl; k++) prog_q.push_back($urandom);
            run_seq(pl, rc, $urandom, dl, 1'b1, $urandom_range(0, 4), 1'b0, dc);
        end

`ifdef LOADER_READBACK_EN
        // Readback sees a corrupted word: err set, RUN and DUMP skipped.
        corrupt = 1'b1;
        prog_q = '{32'h0, 32'h1, 32'h2, 32'h3};
        run_seq(4, 32'd10, 32'h20, 2, 1'b1, 0, 1'b1, dc);
        corrupt = 1'b0;
        prog_q = '{32'h5, 32'h6};
        run_seq(2, 32'd3, 32'h40, 1, 1'b0, 0, 1'b0, dc);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
